// File: rtl/sgb_rom_arb_pkg.sv
// rtl/sgb_rom_arb_pkg.sv - shared types and constants for the SGB ROM port arbiter
package sgb_rom_arb_pkg;

  typedef enum logic [1:0] {IDLE, SNES_WAIT, GB_WAIT} arb_state_t;
  typedef enum logic {REQ_SNES, REQ_GB} req_id_t;

  localparam logic [23:0] GB_BASE_DEFAULT = 24'h100000;
  localparam int          STARVE_W        = 4;

  // GB image offset plus cart address, wrapped to 24 bits and forced word-aligned
  function automatic logic [23:0] gb_word_addr(input logic [23:0] base, input logic [22:0] addr);
    logic [23:0] sum;
    sum = base + {1'b0, addr};
    return {sum[23:1], 1'b0};
  endfunction

endpackage

// File: rtl/sgb_rom_req_latch.sv
// rtl/sgb_rom_req_latch.sv - pending flag and address capture for one requester
module sgb_rom_req_latch #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          issue,
  input  logic          done,
  output logic          pending,
  output logic          valid,
  output logic [AW-1:0] addr_eff,
  output logic [AW-1:0] addr_q
);

  logic in_flight;
  logic accept;

  // completion cycle reopens the latch so a same-cycle request is kept
  assign accept   = req && (!in_flight || done);
  assign valid    = pending || accept;
  assign addr_eff = accept ? addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (done) in_flight <= 1'b0;
      else if (issue) in_flight <= 1'b1;

      if (accept) begin
        pending <= 1'b1;
        addr_q  <= addr;
      end else if (done) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sgb_rom_arbiter.sv
// rtl/sgb_rom_arbiter.sv - SNES/GB arbiter for the shared SDRAM ROM read port
// Optional single-entry GB word cache: define SGB_ROM_GB_CACHE_EN.
module sgb_rom_arbiter
  import sgb_rom_arb_pkg::*;
#(
  parameter logic [23:0] GB_BASE    = GB_BASE_DEFAULT,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snes_req,
  input  logic [23:0] snes_addr,
  output logic [15:0] snes_q,
  output logic        snes_ack,
  input  logic        gb_req,
  input  logic [22:0] gb_addr,
  output logic [7:0]  gb_q,
  output logic        gb_ack,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_q,
  output logic        busy
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state, next_state;
  req_id_t             grant_id;
  logic                snes_issue, gb_issue, snes_done, gb_done;
  logic                snes_pend, gb_pend, snes_valid, gb_valid;
  logic [22:0]         snes_addr_eff, snes_addr_q_unused;
  logic [22:0]         gb_addr_eff, gb_addr_q;
  logic                gb_req_eff, gb_hit;
  logic [7:0]          hit_byte;
  logic [STARVE_W-1:0] starve_cnt;
  logic                unused_snes_bit0;

  assign unused_snes_bit0 = snes_addr[0];

  sgb_rom_req_latch #(.AW(23)) u_snes_latch (
    .clk(clk), .rst_n(rst_n), .req(snes_req), .addr(snes_addr[23:1]),
    .issue(snes_issue), .done(snes_done), .pending(snes_pend),
    .valid(snes_valid), .addr_eff(snes_addr_eff), .addr_q(snes_addr_q_unused)
  );

  sgb_rom_req_latch #(.AW(23)) u_gb_latch (
    .clk(clk), .rst_n(rst_n), .req(gb_req_eff), .addr(gb_addr),
    .issue(gb_issue), .done(gb_done), .pending(gb_pend),
    .valid(gb_valid), .addr_eff(gb_addr_eff), .addr_q(gb_addr_q)
  );

  assign gb_req_eff = gb_req && !gb_hit;
  assign mem_rd     = (state != IDLE);
  assign busy       = snes_pend || gb_pend || (state != IDLE);

`ifdef SGB_ROM_GB_CACHE_EN
  logic        cache_valid;
  logic [23:0] cache_tag;
  logic [15:0] cache_word;

  // a hit on the GB completion cycle would collide on gb_ack, so it goes to memory
  assign gb_hit   = gb_req && cache_valid && !gb_done && (gb_word_addr(GB_BASE, gb_addr) == cache_tag);
  assign hit_byte = gb_addr[0] ? cache_word[15:8] : cache_word[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_word  <= '0;
    end else if (gb_done) begin
      cache_valid <= 1'b1;
      cache_tag   <= mem_addr;
      cache_word  <= mem_q;
    end
  end
`else
  assign gb_hit   = 1'b0;
  assign hit_byte = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_id   = REQ_SNES;
    snes_issue = 1'b0;
    gb_issue   = 1'b0;
    snes_done  = 1'b0;
    gb_done    = 1'b0;
    case (state)
      IDLE: begin
        if (gb_valid && (!snes_valid || starve_cnt == STARVE_LIM)) grant_id = REQ_GB;
        if (snes_valid || gb_valid) begin
          if (grant_id == REQ_GB) begin
            gb_issue   = 1'b1;
            next_state = GB_WAIT;
          end else begin
            snes_issue = 1'b1;
            next_state = SNES_WAIT;
          end
        end
      end
      SNES_WAIT: if (mem_ack) begin
        snes_done  = 1'b1;
        next_state = IDLE;
      end
      GB_WAIT: if (mem_ack) begin
        gb_done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      snes_q     <= '0;
      gb_q       <= '0;
      snes_ack   <= 1'b0;
      gb_ack     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      snes_ack <= snes_done;
      gb_ack   <= gb_done || gb_hit;

      if (snes_issue)    mem_addr <= {snes_addr_eff, 1'b0};
      else if (gb_issue) mem_addr <= gb_word_addr(GB_BASE, gb_addr_eff);

      if (snes_done) snes_q <= mem_q;
      if (gb_done)     gb_q <= gb_addr_q[0] ? mem_q[15:8] : mem_q[7:0];
      else if (gb_hit) gb_q <= hit_byte;

      if (gb_issue || !gb_valid)                   starve_cnt <= '0;
      else if (snes_issue && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sgb_rom_arbiter.sv
// tb/tb_sgb_rom_arbiter.sv - directed vector bench for sgb_rom_arbiter
module tb_sgb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snes_req, gb_req, mem_ack;
  logic [23:0] snes_addr;
  logic [22:0] gb_addr;
  logic [15:0] mem_q;
  logic [15:0] snes_q;
  logic [7:0]  gb_q;
  logic        snes_ack, gb_ack, mem_rd, busy;
  logic [23:0] mem_addr;

  int tests = 0;
  int fails = 0;

  sgb_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .snes_req(snes_req), .snes_addr(snes_addr), .snes_q(snes_q), .snes_ack(snes_ack),
    .gb_req(gb_req), .gb_addr(gb_addr), .gb_q(gb_q), .gb_ack(gb_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_q(mem_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_gb;
    logic [23:0] addr;
    logic [15:0] data;
    logic [23:0] exp_addr;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_gb) begin
      gb_req  = 1'b1;
      gb_addr = v.addr[22:0];
    end else begin
      snes_req  = 1'b1;
      snes_addr = v.addr;
    end
    tick();
    snes_req = 1'b0;
    gb_req   = 1'b0;
    check("mem_rd_rise", mem_rd, 1);
    check("mem_addr", mem_addr, v.exp_addr);
    tick();
    tick();
    check("mem_addr_stable", mem_addr, v.exp_addr);
    mem_ack = 1'b1;
    mem_q   = v.data;
    tick();
    mem_ack = 1'b0;
    check("ack", v.is_gb ? gb_ack : snes_ack, 1);
    check("q", v.is_gb ? {16'h0, gb_q} : {8'h0, snes_q}, v.exp_q);
    check("mem_rd_drop", mem_rd, 0);
    tick();
    check("ack_pulse", {gb_ack, snes_ack}, 0);
  endtask

  int snes_grants;
  int gb_grants;
  int gb_acks;
  bit gb_seen;

  initial begin
    vecs[0] = '{1'b0, 24'h000123, 16'hBEEF, 24'h000122, 16'hBEEF};
    vecs[1] = '{1'b1, 24'h000151, 16'hA55A, 24'h100150, 16'h00A5};
    vecs[2] = '{1'b1, 24'h7FFFFE, 16'h1234, 24'h8FFFFE, 16'h0034};
    vecs[3] = '{1'b0, 24'hFFFFFF, 16'h0F0F, 24'hFFFFFE, 16'h0F0F};
    vecs[4] = '{1'b0, 24'h000000, 16'hFFFF, 24'h000000, 16'hFFFF};
    vecs[5] = '{1'b1, 24'h000000, 16'h1357, 24'h100000, 16'h0057};
    vecs[6] = '{1'b1, 24'h400001, 16'h9ABC, 24'h500000, 16'h009A};
    vecs[7] = '{1'b1, 24'h000150, 16'hA55A, 24'h100150, 16'h005A};

    rst_n = 1'b0; snes_req = 1'b0; gb_req = 1'b0; mem_ack = 1'b0;
    snes_addr = '0; gb_addr = '0; mem_q = '0;
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_acks", {snes_ack, gb_ack}, 0);
    check("rst_q", {snes_q, gb_q}, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // simultaneous requests: SNES first, one idle cycle, then GB
    snes_req = 1'b1; snes_addr = 24'h000010;
    gb_req   = 1'b1; gb_addr   = 23'h000020;
    tick();
    snes_req = 1'b0; gb_req = 1'b0;
    check("sim_first_addr", mem_addr, 24'h000010);
    tick();
    mem_ack = 1'b1; mem_q = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("sim_snes_ack", snes_ack, 1);
    check("sim_gap", mem_rd, 0);
    check("sim_busy_gap", busy, 1);
    tick();
    check("sim_second_rd", mem_rd, 1);
    check("sim_second_addr", mem_addr, 24'h100020);
    mem_ack = 1'b1; mem_q = 16'h2222;
    tick();
    mem_ack = 1'b0;
    check("sim_gb_ack", gb_ack, 1);
    check("sim_gb_q", gb_q, 8'h22);
    tick();
    check("sim_idle", {busy, mem_rd}, 0);

    // overwrite while pending, drop while in flight
    snes_req = 1'b1; snes_addr = 24'h000300;
    tick();
    snes_req = 1'b0;
    gb_req = 1'b1; gb_addr = 23'h000060;
    tick();
    gb_addr = 23'h000071;
    tick();
    gb_req = 1'b0;
    mem_ack = 1'b1; mem_q = 16'h0000;
    tick();
    mem_ack = 1'b0;
    tick();
    check("ovw_addr", mem_addr, 24'h100070);
    gb_req = 1'b1; gb_addr = 23'h000090;
    tick();
    gb_req = 1'b0;
    mem_ack = 1'b1; mem_q = 16'hC3D4;
    tick();
    mem_ack = 1'b0;
    check("ovw_q", gb_q, 8'hC3);
    tick();
    check("drop_idle", {busy, mem_rd}, 0);

    // starvation: GB must win after exactly four SNES grants
    snes_grants = 0; gb_grants = 0; gb_acks = 0; gb_seen = 1'b0;
    snes_req = 1'b1; snes_addr = 24'h000041;
    gb_req   = 1'b1; gb_addr   = 23'h000030;
    for (int t = 0; t < 80 && !gb_seen; t++) begin
      tick();
      gb_req = 1'b0;
      if (gb_ack) gb_acks++;
      if (mem_rd && !mem_ack) begin
        if (mem_addr == 24'h100030) begin
          gb_grants++;
          gb_seen = 1'b1;
        end else begin
          snes_grants++;
        end
        mem_ack = 1'b1; mem_q = 16'h4455;
      end else begin
        mem_ack = 1'b0;
      end
    end
    snes_req = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (gb_ack) gb_acks++;
      mem_ack = mem_rd && !mem_ack;
    end
    mem_ack = 1'b0;
    check("starve_gb_seen", gb_seen, 1);
    check("starve_snes_grants", snes_grants, 4);
    check("starve_gb_acks", gb_acks, 1);
    check("starve_drained", {busy, mem_rd}, 0);

`ifdef SGB_ROM_GB_CACHE_EN
    gb_req = 1'b1; gb_addr = 23'h000200;
    tick();
    gb_req = 1'b0;
    check("cache_miss_addr", mem_addr, 24'h100200);
    mem_ack = 1'b1; mem_q = 16'h7788;
    tick();
    mem_ack = 1'b0;
    check("cache_miss_q", gb_q, 8'h88);
    tick();
    gb_req = 1'b1; gb_addr = 23'h000201;
    tick();
    gb_req = 1'b0;
    check("cache_hit_ack", gb_ack, 1);
    check("cache_hit_q", gb_q, 8'h77);
    check("cache_hit_no_rd", mem_rd, 0);
    tick();
    check("cache_hit_idle", {busy, mem_rd, gb_ack}, 0);
`endif

    // reset mid-transaction, then a stray ack
    snes_req = 1'b1; snes_addr = 24'h000500;
    tick();
    snes_req = 1'b0;
    check("mid_rd", mem_rd, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", mem_rd, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_q", {snes_q, gb_q}, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_q = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("stray_acks", {snes_ack, gb_ack, mem_rd}, 0);
    tick();
    check("stray_after", {snes_ack, gb_ack, busy, snes_q}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
